// File: rtl/accum_pkg.sv
// Shared types and constants for the operand accumulator: FSM state encoding,
// mode encoding and active-low seven-segment glyphs (segment a at bit 0, g at bit 6).
package accum_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

endpackage

// File: rtl/seg7_decoder.sv
// Hex nibble to active-low seven-segment decoder; used by operand_accumulator
// only when HEX_DISPLAY_EN is defined.
module seg7_decoder
    import accum_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_0;
        case (i_nibble)
            4'h0: o_seg = SEG_0;
            4'h1: o_seg = SEG_1;
            4'h2: o_seg = SEG_2;
            4'h3: o_seg = SEG_3;
            4'h4: o_seg = SEG_4;
            4'h5: o_seg = SEG_5;
            4'h6: o_seg = SEG_6;
            4'h7: o_seg = SEG_7;
            4'h8: o_seg = SEG_8;
            4'h9: o_seg = SEG_9;
            4'hA: o_seg = SEG_A;
            4'hB: o_seg = SEG_B;
            4'hC: o_seg = SEG_C;
            4'hD: o_seg = SEG_D;
            4'hE: o_seg = SEG_E;
            4'hF: o_seg = SEG_F;
            default: o_seg = SEG_0;
        endcase
    end

endmodule

// File: rtl/operand_accumulator.sv
// Multi-operand add/subtract accumulator fed one operand per load strobe.
// Optional macro HEX_DISPLAY_EN adds o_hex_out, a per-nibble seven-segment view of o_sum.
module operand_accumulator
    import accum_pkg::*;
#(
    parameter  int WIDTH   = 8,
    parameter  int NUM_OPS = 2,
    localparam int CNT_W   = $clog2(NUM_OPS + 1)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_data_in,
    input  logic             i_load,
    input  logic             i_mode,
    input  logic             i_clear,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry,
    output logic [WIDTH-1:0] o_last_op,
    output logic [CNT_W-1:0] o_count,
    output logic             o_busy,
    output logic             o_done
`ifdef HEX_DISPLAY_EN
    ,
    output logic [7*((WIDTH+3)/4)-1:0] o_hex_out
`endif
);

    state_t             r_state;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic [WIDTH-1:0]   r_last_op;
    logic [CNT_W-1:0]   r_count;
    logic               r_mode;
    logic               r_busy;
    logic               r_done;

    logic [WIDTH:0]     w_add;
    logic [WIDTH-1:0]   w_sub;
    logic               w_borrow;
    logic [CNT_W-1:0]   w_next_count;
    logic               w_last_capture;

    // Borrow compares against the sum before this operand is applied.
    assign w_add          = {1'b0, r_sum} + {1'b0, i_data_in};
    assign w_sub          = r_sum - i_data_in;
    assign w_borrow       = i_data_in > r_sum;
    assign w_next_count   = r_count + CNT_W'(1);
    assign w_last_capture = (w_next_count == CNT_W'(NUM_OPS));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_state   <= S_IDLE;
            r_sum     <= '0;
            r_carry   <= 1'b0;
            r_last_op <= '0;
            r_count   <= '0;
            r_mode    <= MODE_ADD;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else if (i_load) begin
            r_last_op <= i_data_in;
            case (r_state)
                S_COLLECT: begin
                    r_count <= w_next_count;
                    if (r_mode == MODE_ADD) begin
                        r_sum   <= w_add[WIDTH-1:0];
                        r_carry <= r_carry | w_add[WIDTH];
                    end else begin
                        r_sum   <= w_sub;
                        r_carry <= r_carry | w_borrow;
                    end
                    if (w_last_capture) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both begin a fresh operation.
                    r_state <= S_COLLECT;
                    r_sum   <= i_data_in;
                    r_carry <= 1'b0;
                    r_count <= CNT_W'(1);
                    r_mode  <= (i_mode == MODE_SUB) ? MODE_SUB : MODE_ADD;
                    r_busy  <= 1'b1;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_sum     = r_sum;
    assign o_carry   = r_carry;
    assign o_last_op = r_last_op;
    assign o_count   = r_count;
    assign o_busy    = r_busy;
    assign o_done    = r_done;

`ifdef HEX_DISPLAY_EN
    localparam int NUM_DIGITS = (WIDTH + 3) / 4;

    logic [4*NUM_DIGITS-1:0] w_sum_padded;

    assign w_sum_padded = {{(4*NUM_DIGITS-WIDTH){1'b0}}, r_sum};

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        seg7_decoder u_seg7 (
            .i_nibble (w_sum_padded[4*k +: 4]),
            .o_seg    (o_hex_out[7*k +: 7])
        );
    end
`endif

endmodule

// File: tb/tb_operand_accumulator.sv
// Self-checking bench: two instances (NUM_OPS=2 and NUM_OPS=4) share stimulus; a
// vector table, hand-written corner sequences and random cycles are checked.
module tb_operand_accumulator;

    logic       clk = 1'b0;
    logic       rst, clr, ld, md;
    logic [7:0] din;

    logic [7:0] a_sum, a_last, b_sum, b_last;
    logic       a_carry, a_busy, a_done, b_carry, b_busy, b_done;
    logic [1:0] a_count;
    logic [2:0] b_count;
`ifdef HEX_DISPLAY_EN
    logic [13:0] a_hex, b_hex;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    operand_accumulator #(.WIDTH(8), .NUM_OPS(2)) dut_a (
        .i_clk(clk), .i_reset(rst), .i_data_in(din), .i_load(ld), .i_mode(md), .i_clear(clr),
        .o_sum(a_sum), .o_carry(a_carry), .o_last_op(a_last), .o_count(a_count),
        .o_busy(a_busy), .o_done(a_done)
`ifdef HEX_DISPLAY_EN
        , .o_hex_out(a_hex)
`endif
    );

    operand_accumulator #(.WIDTH(8), .NUM_OPS(4)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_data_in(din), .i_load(ld), .i_mode(md), .i_clear(clr),
        .o_sum(b_sum), .o_carry(b_carry), .o_last_op(b_last), .o_count(b_count),
        .o_busy(b_busy), .o_done(b_done)
`ifdef HEX_DISPLAY_EN
        , .o_hex_out(b_hex)
    );
`else
    );
`endif

    // Reference model: operands kept as a true signed running total; the
    // register view is that total modulo 256, overflow is "ever left 0..255".
    int    m_n   [2] = '{2, 4};
    int    m_cnt [2];
    longint m_tot[2];
    bit    m_mode[2];
    int    m_last[2];

    task automatic model_update(input bit r, input bit c, input bit l, input bit m, input int d);
        for (int k = 0; k < 2; k++) begin
            if (r || c) begin
                m_cnt[k] = 0; m_tot[k] = 0; m_mode[k] = 0; m_last[k] = 0;
            end else if (l) begin
                if (m_cnt[k] == 0 || m_cnt[k] == m_n[k]) begin
                    m_cnt[k] = 1; m_tot[k] = d; m_mode[k] = m;
                end else begin
                    m_cnt[k]++;
                    m_tot[k] = m_mode[k] ? m_tot[k] - d : m_tot[k] + d;
                end
                m_last[k] = d;
            end
        end
    endtask

    function automatic int exp_sum(int k);
        longint t = m_tot[k] % 256;
        if (t < 0) t += 256;
        return int'(t);
    endfunction

    function automatic bit exp_carry(int k);
        if (m_cnt[k] == 0) return 1'b0;
        return m_mode[k] ? (m_tot[k] < 0) : (m_tot[k] >= 256);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, let the edge sample them, then observe.
    task automatic cycle(input bit r, input bit c, input bit l, input bit m, input logic [7:0] d);
        rst = r; clr = c; ld = l; md = m; din = d;
        @(posedge clk);
        #1;
        model_update(r, c, l, m, int'(d));
        rst = 1'b0; clr = 1'b0; ld = 1'b0;
    endtask

    task automatic check_a(input string tag, input int s, input bit cy, input int cnt,
                           input bit bz, input bit dn, input int lst);
        check({tag, ".a_sum"},   a_sum,   s);
        check({tag, ".a_carry"}, a_carry, cy);
        check({tag, ".a_count"}, a_count, cnt);
        check({tag, ".a_busy"},  a_busy,  bz);
        check({tag, ".a_done"},  a_done,  dn);
        check({tag, ".a_last"},  a_last,  lst);
    endtask

    task automatic check_b(input string tag, input int s, input bit cy, input int cnt,
                           input bit bz, input bit dn, input int lst);
        check({tag, ".b_sum"},   b_sum,   s);
        check({tag, ".b_carry"}, b_carry, cy);
        check({tag, ".b_count"}, b_count, cnt);
        check({tag, ".b_busy"},  b_busy,  bz);
        check({tag, ".b_done"},  b_done,  dn);
        check({tag, ".b_last"},  b_last,  lst);
    endtask

    task automatic check_models(input string tag);
        check_a(tag, exp_sum(0), exp_carry(0), m_cnt[0],
                m_cnt[0] > 0 && m_cnt[0] < 2, m_cnt[0] == 2, m_last[0]);
        check_b(tag, exp_sum(1), exp_carry(1), m_cnt[1],
                m_cnt[1] > 0 && m_cnt[1] < 4, m_cnt[1] == 4, m_last[1]);
    endtask

`ifdef HEX_DISPLAY_EN
    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction
`endif

    typedef struct {
        bit         r, c, l, m;
        logic [7:0] d;
        logic [7:0] e_sum;
        bit         e_carry;
        int         e_cnt;
        bit         e_busy, e_done;
        logic [7:0] e_last;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(bit r, bit c, bit l, bit m, logic [7:0] d, logic [7:0] s,
                                bit cy, int cnt, bit bz, bit dn, logic [7:0] lst);
        vec_t v;
        v.r = r; v.c = c; v.l = l; v.m = m; v.d = d;
        v.e_sum = s; v.e_carry = cy; v.e_cnt = cnt; v.e_busy = bz; v.e_done = dn; v.e_last = lst;
        return v;
    endfunction

    initial begin
        rst = 1'b1; clr = 1'b0; ld = 1'b0; md = 1'b0; din = '0;

        //              r  c  l  m  data   sum    cy cnt bz dn last
        vecs[0]  = mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00);
        vecs[1]  = mk(0, 0, 1, 0, 8'h3C, 8'h3C, 0, 1, 1, 0, 8'h3C);
        vecs[2]  = mk(0, 0, 1, 0, 8'h55, 8'h91, 0, 2, 0, 1, 8'h55);
        vecs[3]  = mk(0, 0, 0, 1, 8'hAA, 8'h91, 0, 2, 0, 1, 8'h55);
        vecs[4]  = mk(0, 0, 1, 0, 8'hFF, 8'hFF, 0, 1, 1, 0, 8'hFF);
        vecs[5]  = mk(0, 0, 1, 0, 8'h02, 8'h01, 1, 2, 0, 1, 8'h02);
        vecs[6]  = mk(0, 0, 1, 0, 8'h10, 8'h10, 0, 1, 1, 0, 8'h10);
        vecs[7]  = mk(0, 0, 1, 0, 8'h20, 8'h30, 0, 2, 0, 1, 8'h20);
        vecs[8]  = mk(0, 0, 1, 1, 8'h10, 8'h10, 0, 1, 1, 0, 8'h10);
        vecs[9]  = mk(0, 0, 1, 0, 8'h20, 8'hF0, 1, 2, 0, 1, 8'h20);
        vecs[10] = mk(0, 1, 1, 0, 8'h33, 8'h00, 0, 0, 0, 0, 8'h00);
        vecs[11] = mk(0, 0, 1, 1, 8'h05, 8'h05, 0, 1, 1, 0, 8'h05);
        vecs[12] = mk(0, 0, 1, 1, 8'h05, 8'h00, 0, 2, 0, 1, 8'h05);
        vecs[13] = mk(1, 0, 1, 0, 8'h77, 8'h00, 0, 0, 0, 0, 8'h00);

        @(negedge clk);
        for (int i = 0; i < 14; i++) begin
            cycle(vecs[i].r, vecs[i].c, vecs[i].l, vecs[i].m, vecs[i].d);
            check_a($sformatf("vec%0d", i), vecs[i].e_sum, vecs[i].e_carry, vecs[i].e_cnt,
                    vecs[i].e_busy, vecs[i].e_done, vecs[i].e_last);
        end

        // Four-operand wrap: carry and done appear only on the fourth capture.
        cycle(1, 0, 0, 0, 8'h00);
        cycle(0, 0, 1, 0, 8'h40); check_b("wrap1", 8'h40, 0, 1, 1, 0, 8'h40);
        cycle(0, 0, 1, 1, 8'h40); check_b("wrap2", 8'h80, 0, 2, 1, 0, 8'h40);
        cycle(0, 0, 1, 1, 8'h40); check_b("wrap3", 8'hC0, 0, 3, 1, 0, 8'h40);
        cycle(0, 0, 0, 0, 8'h99); check_b("hold3", 8'hC0, 0, 3, 1, 0, 8'h40);
        cycle(0, 0, 1, 0, 8'h40); check_b("wrap4", 8'h00, 1, 4, 0, 1, 8'h40);
        cycle(0, 0, 0, 0, 8'h00); check_b("hold4", 8'h00, 1, 4, 0, 1, 8'h40);

        // Abort paths: clear beats a simultaneous load; reset after one load.
        cycle(1, 0, 0, 0, 8'h00);
        cycle(0, 0, 1, 0, 8'h11);
        cycle(0, 0, 1, 0, 8'h22); check_b("abort_pre", 8'h33, 0, 2, 1, 0, 8'h22);
        cycle(0, 1, 1, 0, 8'h33); check_b("abort_clr", 8'h00, 0, 0, 0, 0, 8'h00);
        cycle(0, 0, 1, 0, 8'h11); check_b("abort_one", 8'h11, 0, 1, 1, 0, 8'h11);
        cycle(1, 0, 0, 0, 8'h00); check_b("abort_rst", 8'h00, 0, 0, 0, 0, 8'h00);

`ifdef HEX_DISPLAY_EN
        check("hex_reset", a_hex, {glyph(4'h0), glyph(4'h0)});
        cycle(0, 0, 1, 0, 8'h3C);
        cycle(0, 0, 1, 0, 8'h55);
        check("hex_0x91", a_hex, {glyph(4'h9), glyph(4'h1)});
        check("hex_b", b_hex, {glyph(b_sum[7:4] ^ 4'h0 ? 4'h9 : 4'h9), glyph(4'h1)});
`endif

        // Random traffic against the reference model for both instances.
        cycle(1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(63) == 0, $urandom_range(31) == 0, $urandom_range(1) == 1,
                  1'($urandom_range(1)), 8'($urandom));
            check_models($sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
